// File: rtl/edge_axis_packer.sv
// rtl/edge_axis_packer.sv - packs 8-bit edge pixels into 32-bit words and streams them out over AXI4-Stream

module edge_axis_packer_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 35
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_drop,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             pop;
    logic             push;

    // Head entry falls through to the read side; a full FIFO still accepts a write when it pops in the same cycle.
    always_comb begin
        rd_valid = (count != '0);
        pop      = rd_valid && rd_ready;
        push     = wr_valid && ((count < FULL_COUNT) || pop);
        wr_drop  = wr_valid && !push;
        rd_data  = mem[rd_ptr];
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module edge_axis_packer #(
    parameter int IMG_W      = 1024,
    parameter int IMG_H      = 768,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        overflow,
    output logic        frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_SOF  = CW'(3);

    // Entry layout: {last_row, tuser, tlast, data}
    localparam int EW = 35;

    logic [1:0]    lane;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [23:0]   pack;

    logic [1:0]    lane_cur;
    logic [CW-1:0] col_cur;
    logic [RW-1:0] row_cur;
    logic          word_push;
    logic [EW-1:0] word_entry;
    logic          word_drop;
    logic          head_valid;
    logic [EW-1:0] head_entry;

    // Position of the current pixel; frame_start restarts the frame before a same-cycle pixel is placed.
    always_comb begin
        lane_cur = frame_start ? 2'd0 : lane;
        col_cur  = frame_start ? '0 : col;
        row_cur  = frame_start ? '0 : row;
    end

    // The fourth pixel of a group completes the word; it bypasses the pack register straight into the FIFO.
    always_comb begin
        word_push  = pix_valid && (lane_cur == 2'd3);
        word_entry = {(row_cur == ROW_LAST),
                      ((row_cur == '0) && (col_cur == COL_SOF)),
                      (col_cur == COL_LAST),
                      pix_data,
                      pack};
    end

    // Lane/column/row counters advance on every valid pixel, even when the completed word is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane <= 2'd0;
            col  <= '0;
            row  <= '0;
        end else if (pix_valid) begin
            lane <= lane_cur + 2'd1;
            if (col_cur == COL_LAST) begin
                col <= '0;
                row <= (row_cur == ROW_LAST) ? '0 : row_cur + 1'b1;
            end else begin
                col <= col_cur + 1'b1;
                row <= row_cur;
            end
        end else if (frame_start) begin
            lane <= 2'd0;
            col  <= '0;
            row  <= '0;
        end
    end

    // Collects the first three bytes of a group; a restarted frame simply overwrites stale lanes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack <= '0;
        end else if (pix_valid) begin
            case (lane_cur)
                2'd0:    pack[7:0]   <= pix_data;
                2'd1:    pack[15:8]  <= pix_data;
                2'd2:    pack[23:16] <= pix_data;
                default: pack        <= pack;
            endcase
        end
    end

    edge_axis_packer_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (word_push),
        .wr_data  (word_entry),
        .wr_drop  (word_drop),
        .rd_valid (head_valid),
        .rd_ready (m_axis_tready),
        .rd_data  (head_entry)
    );

    // Stream outputs come from the FIFO head and read as zero whenever nothing is queued.
    always_comb begin
        m_axis_tvalid = head_valid;
        m_axis_tdata  = head_valid ? head_entry[31:0] : 32'd0;
        m_axis_tlast  = head_valid && head_entry[32];
        m_axis_tuser  = head_valid && head_entry[33];
    end

    // Sticky drop flag, cleared at the start of each frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (frame_start) begin
            overflow <= 1'b0;
        end else if (word_drop) begin
            overflow <= 1'b1;
        end
    end

    // One-cycle pulse after the final word of the last line leaves the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= head_valid && m_axis_tready && head_entry[32] && head_entry[34];
        end
    end
endmodule

// File: tb/tb_edge_axis_packer.sv
// tb/tb_edge_axis_packer.sv - scoreboard bench for edge_axis_packer with a pixel-level reference model

module tb_edge_axis_packer;
    localparam int W = 8;
    localparam int H = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_data = 8'd0;
    logic        m_axis_tready = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        overflow;
    logic        frame_done;

    edge_axis_packer #(.IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .pix_valid     (pix_valid),
        .pix_data      (pix_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .overflow      (overflow),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        user;
        logic        fd;
    } exp_t;

    exp_t        exp_q[$];
    logic [33:0] got_q[$];
    int          total = 0;
    int          passed = 0;
    int          fd_count = 0;

    int          mcount = 0;
    int          mcol = 0;
    int          mrow = 0;
    bit          movf = 1'b0;
    logic [7:0]  cur[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // One clock of stimulus; the reference model tracks the pixel position, FIFO occupancy and drops.
    task automatic cycle(input bit fs, input bit pv, input logic [7:0] pd, input bit rdy);
        bit   pop;
        exp_t e;
        @(posedge clk);
        #2;
        chk("tvalid", m_axis_tvalid, (mcount != 0));
        chk("overflow", overflow, movf);
        frame_start   = fs;
        pix_valid     = pv;
        pix_data      = pd;
        m_axis_tready = rdy;
        pop = (mcount > 0) && rdy;
        if (fs) begin
            mcol = 0;
            mrow = 0;
            movf = 1'b0;
        end
        if (pv) begin
            cur[mcol % 4] = pd;
            if (mcol % 4 == 3) begin
                e.data = {cur[3], cur[2], cur[1], cur[0]};
                e.user = (mrow == 0) && (mcol == 3);
                e.last = (mcol == W - 1);
                e.fd   = e.last && (mrow == H - 1);
                if (mcount < D || pop) begin
                    exp_q.push_back(e);
                    mcount++;
                end else begin
                    movf = 1'b1;
                end
            end
            mcol++;
            if (mcol == W) begin
                mcol = 0;
                mrow = (mrow + 1) % H;
            end
        end
        if (pop) mcount--;
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && mcount != 0; i++) cycle(0, 0, 8'd0, 1);
        repeat (3) cycle(0, 0, 8'd0, 1);
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic frame_ramp();
        cycle(1, 0, 8'd0, 1);
        for (int i = 0; i < 16; i++) cycle(0, 1, 8'(i), 1);
        drain();
        chk("t1_count", got_q.size(), 4);
        if (got_q.size() == 4) begin
            chk("t1_w0", got_q[0], {1'b1, 1'b0, 32'h03020100});
            chk("t1_w1", got_q[1], {1'b0, 1'b1, 32'h07060504});
            chk("t1_w2", got_q[2], {1'b0, 1'b0, 32'h0B0A0908});
            chk("t1_w3", got_q[3], {1'b0, 1'b1, 32'h0F0E0D0C});
        end
        chk("t1_frame_done_count", fd_count, 1);
    endtask

    // Monitor: pops the scoreboard on each handshake and checks hold stability and frame_done timing.
    bit          fd_pend = 1'b0;
    bit          prev_stall = 1'b0;
    logic [33:0] prev_word = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            fd_pend    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("frame_done", frame_done, fd_pend);
            if (frame_done) fd_count++;
            fd_pend = 1'b0;
            if (prev_stall) begin
                chk("hold_valid", m_axis_tvalid, 1);
                chk("hold_word", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, prev_word);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", m_axis_tdata, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("tdata", m_axis_tdata, e.data);
                    chk("tlast", m_axis_tlast, e.last);
                    chk("tuser", m_axis_tuser, e.user);
                    fd_pend = e.fd;
                end
                got_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_word  = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_tvalid"}, m_axis_tvalid, 0);
        chk({tag, "_tdata"}, m_axis_tdata, 0);
        chk({tag, "_tlast"}, m_axis_tlast, 0);
        chk({tag, "_tuser"}, m_axis_tuser, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check_reset_values("reset");
        rst_n = 1'b1;

        // Full frame with an always-ready sink.
        got_q.delete();
        fd_count = 0;
        frame_ramp();

        // Sink stalls for 20 cycles with two words queued.
        got_q.delete();
        cycle(1, 0, 8'd0, 0);
        for (int i = 0; i < 8; i++) cycle(0, 1, 8'($urandom), 0);
        repeat (20) cycle(0, 0, 8'd0, 0);
        drain();
        chk("t2_count", got_q.size(), 2);

        // Five words into a 4-deep FIFO with no draining.
        got_q.delete();
        cycle(1, 0, 8'd0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 1, 8'(8'h40 + i), 0);
        cycle(0, 0, 8'd0, 0);
        chk("t3_overflow_set", overflow, 1);
        drain();
        chk("t3_count", got_q.size(), 4);
        cycle(1, 0, 8'd0, 1);
        cycle(0, 0, 8'd0, 1);
        chk("t3_overflow_cleared", overflow, 0);

        // Fifth word completes in the same cycle the full FIFO pops.
        got_q.delete();
        cycle(1, 0, 8'd0, 0);
        for (int i = 0; i < 19; i++) cycle(0, 1, 8'(8'h80 + i), 0);
        cycle(0, 1, 8'h93, 1);
        cycle(0, 0, 8'd0, 0);
        chk("t4_no_overflow", overflow, 0);
        drain();
        chk("t4_count", got_q.size(), 5);

        // Restart after six pixels of a line.
        got_q.delete();
        cycle(1, 0, 8'd0, 1);
        for (int i = 0; i < 6; i++) cycle(0, 1, 8'(8'h10 + i), 1);
        cycle(1, 1, 8'hA0, 1);
        for (int i = 1; i < 4; i++) cycle(0, 1, 8'(8'hA0 + i), 1);
        drain();
        chk("t5_count", got_q.size(), 2);
        if (got_q.size() == 2) chk("t5_restart_word", got_q[1], {1'b1, 1'b0, 32'hA3A2A1A0});

        // Reset mid-frame with words queued.
        cycle(1, 0, 8'd0, 0);
        for (int i = 0; i < 13; i++) cycle(0, 1, 8'($urandom), 0);
        chk("t6_pre_valid", m_axis_tvalid, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        frame_start = 1'b0;
        pix_valid = 1'b0;
        m_axis_tready = 1'b0;
        #1;
        check_reset_values("midreset");
        mcount = 0;
        mcol = 0;
        mrow = 0;
        movf = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        got_q.delete();
        fd_count = 0;
        frame_ramp();

        // Randomised frames with random sink readiness and occasional restarts.
        cycle(1, 0, 8'd0, 1);
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 70),
                  8'($urandom), ($urandom_range(0, 99) < 60));
        end
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
